// File: rtl/jtframe_prog_packer_pkg.sv
// Shared types for the ROM-download byte packer: FIFO entry layout,
// byte-lane mask constants and the write FSM state encoding.
package jtframe_prog_pkg;

    // Widest word address a 25-bit byte address can produce.
    // Entries always carry this width; the top trims it to SDRAMW.
    localparam int ADDR_MAX_W = 24;

    // Byte masks are active-low per lane; bit0 is the low byte.
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_W    = 2'b00;
    localparam logic [1:0] MASK_NONE = 2'b11;

    typedef struct packed {
        logic [ADDR_MAX_W-1:0] addr;
        logic [15:0]           data;
        logic [1:0]            mask;
    } prog_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } prog_state_t;

    // Folds a byte into the complementary lane of an existing half-word entry.
    function automatic prog_entry_t merge_entry(input prog_entry_t tail,
                                                input logic [7:0]  din,
                                                input logic [1:0]  mask);
        merge_entry = tail;
        if (!mask[0]) merge_entry.data[7:0]  = din;
        if (!mask[1]) merge_entry.data[15:8] = din;
        merge_entry.mask = MASK_W;
    endfunction

endpackage

// File: rtl/jtframe_prog_packer_if.sv
// SDRAM programming bus between the packer (master) and the SDRAM controller (slave).
interface jtframe_prog_packer_if #(
    parameter int SDRAMW = 22
);
    logic [SDRAMW-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic [1:0]        prog_mask;
    logic              prog_we;
    logic              prog_rdy;

    modport master (output prog_addr, prog_data, prog_mask, prog_we, input prog_rdy);
    modport slave  (input  prog_addr, prog_data, prog_mask, prog_we, output prog_rdy);
endinterface

// File: rtl/jtframe_prog_packer_fifo.sv
// Small entry FIFO for the packer. Besides push/pop it exposes the newest
// entry (tail) and lets the caller rewrite it in place, which is how two
// bytes of one word get merged into a single SDRAM write.
module jtframe_prog_fifo
    import jtframe_prog_pkg::*;
#(
    parameter int DEPTH = 5
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  prog_entry_t i_push_data,
    input  logic        i_pop,
    input  logic        i_tail_we,
    input  prog_entry_t i_tail_data,
    output prog_entry_t o_head,
    output prog_entry_t o_tail,
    output logic        o_full,
    output logic        o_empty,
    output logic        o_multi
);
    localparam int AW = $clog2(DEPTH);

    prog_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_rd_idx;
    logic [AW-1:0] r_wr_idx;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_tail_idx;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
        return (idx == AW'(DEPTH - 1)) ? '0 : idx + AW'(1);
    endfunction

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    // Only with two or more entries is the tail distinct from the head.
    assign o_multi    = (r_count >= (AW+1)'(2));
    assign w_pop      = i_pop && !o_empty;
    assign w_push     = i_push && (!o_full || w_pop);
    assign w_tail_idx = (r_wr_idx == '0) ? AW'(DEPTH - 1) : r_wr_idx - AW'(1);
    assign o_head     = r_mem[r_rd_idx];
    assign o_tail     = r_mem[w_tail_idx];

    // Storage: append a new entry or rewrite the newest one.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_idx] <= i_push_data;
        end else if (i_tail_we) begin
            r_mem[w_tail_idx] <= i_tail_data;
        end
    end

    // Read/write indices and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_idx <= next_idx(r_wr_idx);
            if (w_pop)  r_rd_idx <= next_idx(r_rd_idx);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/jtframe_prog_packer.sv
// ROM download byte packer: turns the ioctl byte stream into 16-bit SDRAM
// writes with byte masks, merging the two halves of a word when possible.
// Optional macro JTFRAME_PROG_BSWAP_EN swaps the byte lanes for big-endian
// ROM images (even byte address goes to the high byte).
module jtframe_prog_packer
    import jtframe_prog_pkg::*;
#(
    parameter int SDRAMW = 22,
    parameter int FIFOD  = 4
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         downloading,
    input  logic [24:0]                  ioctl_addr,
    input  logic [7:0]                   ioctl_dout,
    input  logic                         ioctl_wr,
    jtframe_prog_packer_if.master        prog,
    output logic                         dwnld_busy,
    output logic                         overflow
);
    prog_state_t       r_state;
    prog_state_t       w_state_next;
    logic [SDRAMW-1:0] r_prog_addr;
    logic [15:0]       r_prog_data;
    logic [1:0]        r_prog_mask;
    logic              r_overflow;
    logic              r_dl_prev;
    logic              w_load;
    logic              w_pop;
    logic              w_prog_we;
    logic              w_in;
    logic              w_merge;
    logic              w_push;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic              w_multi;
    logic [1:0]        w_new_mask;
    prog_entry_t       w_new;
    prog_entry_t       w_merged;
    prog_entry_t       w_head;
    prog_entry_t       w_tail;
    logic              w_unused;

    // Byte lane selection from the byte address LSB.
    always_comb begin
`ifdef JTFRAME_PROG_BSWAP_EN
        w_new_mask = ioctl_addr[0] ? MASK_LO : MASK_HI;
`else
        w_new_mask = ioctl_addr[0] ? MASK_HI : MASK_LO;
`endif
        w_new.addr = ADDR_MAX_W'(ioctl_addr[SDRAMW:1]);
        w_new.data = {2{ioctl_dout}};
        w_new.mask = w_new_mask;
    end

    // A merge needs no free slot, so it is taken even when the FIFO is full.
    // The tail must not be the head, which is already on (or headed for) the bus.
    assign w_in     = downloading && ioctl_wr;
    assign w_merge  = w_in && w_multi && (w_tail.addr == w_new.addr)
                      && (w_tail.mask == ~w_new_mask);
    assign w_push   = w_in && !w_merge && (!w_full || w_pop);
    assign w_drop   = w_in && !w_merge && w_full && !w_pop;
    assign w_merged = merge_entry(w_tail, ioctl_dout, w_new_mask);

    // One slot holds the word currently on the bus; FIFOD more queue behind it.
    jtframe_prog_fifo #(
        .DEPTH (FIFOD + 1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_new),
        .i_pop       (w_pop),
        .i_tail_we   (w_merge),
        .i_tail_data (w_merged),
        .o_head      (w_head),
        .o_tail      (w_tail),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_multi     (w_multi)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next state: start on a queued entry, finish on prog_rdy.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty)      w_state_next = ST_WRITE;
            ST_WRITE: if (prog.prog_rdy) w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: load in IDLE, request and pop in WRITE.
    always_comb begin
        w_load    = 1'b0;
        w_pop     = 1'b0;
        w_prog_we = 1'b0;
        case (r_state)
            ST_IDLE:  w_load = !w_empty;
            ST_WRITE: begin
                w_prog_we = 1'b1;
                w_pop     = prog.prog_rdy;
            end
            default: ;
        endcase
    end

    // Bus registers: captured from the FIFO head, held stable through WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_prog_mask <= MASK_NONE;
        end else if (w_load) begin
            r_prog_addr <= w_head.addr[SDRAMW-1:0];
            r_prog_data <= w_head.data;
            r_prog_mask <= w_head.mask;
        end
    end

    // Sticky drop flag, cleared when a new download session starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_dl_prev  <= 1'b0;
        end else begin
            r_dl_prev <= downloading;
            if (w_drop)                         r_overflow <= 1'b1;
            else if (downloading && !r_dl_prev) r_overflow <= 1'b0;
        end
    end

    assign prog.prog_addr = r_prog_addr;
    assign prog.prog_data = r_prog_data;
    assign prog.prog_mask = r_prog_mask;
    assign prog.prog_we   = w_prog_we;
    assign overflow       = r_overflow;
    assign dwnld_busy     = downloading || !w_empty || (r_state == ST_WRITE);

    // Address bits above the SDRAM word range are intentionally ignored.
    assign w_unused = ^{ioctl_addr, w_head.addr};

endmodule

// File: tb/tb_jtframe_prog_packer.sv
module tb_jtframe_prog_packer;
    localparam int SDRAMW = 22;
    localparam int FIFOD  = 4;
    localparam int TMO    = 20;

    typedef struct packed {
        logic [SDRAMW-1:0] addr;
        logic [15:0]       data;
        logic [1:0]        mask;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wr = 1'b0;
    logic        dwnld_busy;
    logic        overflow;

    int  tests = 0;
    int  fails = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];

    jtframe_prog_packer_if #(.SDRAMW(SDRAMW)) u_if ();

    jtframe_prog_packer #(.SDRAMW(SDRAMW), .FIFOD(FIFOD)) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .prog        (u_if),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Capture every completed write (request and done in the same cycle).
    always @(negedge clk) begin
        if (!rst && u_if.prog_we && u_if.prog_rdy)
            obs_q.push_back({u_if.prog_addr, u_if.prog_data, u_if.prog_mask});
    end

    function automatic logic [1:0] lane_mask(input logic b0);
`ifdef JTFRAME_PROG_BSWAP_EN
        return b0 ? 2'b10 : 2'b01;
`else
        return b0 ? 2'b01 : 2'b10;
`endif
    endfunction

    function automatic wr_t byte_word(input logic [24:0] a, input logic [7:0] d);
        return {a[SDRAMW:1], d, d, lane_mask(a[0])};
    endfunction

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(posedge clk); #1;
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_we(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            if (u_if.prog_we) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic release_writes(input int n, output int done);
        bit ok;
        done = 0;
        for (int i = 0; i < n; i++) begin
            wait_we(ok);
            if (!ok) break;
            u_if.prog_rdy = 1'b1;
            @(posedge clk); #1;
            u_if.prog_rdy = 1'b0;
            done++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        downloading = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests += 6;
        if (u_if.prog_we !== 1'b0) begin fails++; $display("FAIL rst_we got %b want 0", u_if.prog_we); end
        if (u_if.prog_addr !== '0) begin fails++; $display("FAIL rst_addr got %h want 0", u_if.prog_addr); end
        if (u_if.prog_data !== 16'h0) begin fails++; $display("FAIL rst_data got %h want 0", u_if.prog_data); end
        if (u_if.prog_mask !== 2'b11) begin fails++; $display("FAIL rst_mask got %b want 11", u_if.prog_mask); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf got %b want 0", overflow); end
        if (dwnld_busy !== 1'b1) begin fails++; $display("FAIL rst_busy_hi got %b want 1", dwnld_busy); end
        downloading = 1'b0;
        #1;
        tests++;
        if (dwnld_busy !== 1'b0) begin fails++; $display("FAIL rst_busy_lo got %b want 0", dwnld_busy); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        wr_t e, o;
        downloading = 1'b1;
        @(posedge clk); #1;
        u_if.prog_rdy = 1'b1;                 // stray done pulse while idle
        @(posedge clk); #1;
        u_if.prog_rdy = 1'b0;
        tests++;
        if (u_if.prog_we !== 1'b0) begin fails++; $display("FAIL idle_rdy we got %b want 0", u_if.prog_we); end
        exp_q.push_back(byte_word(25'h000005, 8'hA5));
        send_byte(25'h000005, 8'hA5);
        tests++;
        if (u_if.prog_we !== 1'b0) begin fails++; $display("FAIL lat1_we got %b want 0", u_if.prog_we); end
        @(posedge clk); #1;
        tests += 4;
        if (u_if.prog_we !== 1'b1) begin fails++; $display("FAIL lat2_we got %b want 1", u_if.prog_we); end
        if (u_if.prog_addr !== 22'd2) begin fails++; $display("FAIL single_addr got %h want 2", u_if.prog_addr); end
        if (u_if.prog_data !== 16'hA5A5) begin fails++; $display("FAIL single_data got %h want a5a5", u_if.prog_data); end
        if (u_if.prog_mask !== lane_mask(1'b1)) begin fails++; $display("FAIL single_mask got %b want %b", u_if.prog_mask, lane_mask(1'b1)); end
        repeat (5) @(posedge clk);
        #1;
        tests += 2;
        if (u_if.prog_we !== 1'b1) begin fails++; $display("FAIL hold_we got %b want 1", u_if.prog_we); end
        if (u_if.prog_addr !== 22'd2) begin fails++; $display("FAIL hold_addr got %h want 2", u_if.prog_addr); end
        u_if.prog_rdy = 1'b1;
        @(posedge clk); #1;
        u_if.prog_rdy = 1'b0;
        tests += 2;
        if (u_if.prog_we !== 1'b0) begin fails++; $display("FAIL done_we got %b want 0", u_if.prog_we); end
        if (dwnld_busy !== downloading) begin fails++; $display("FAIL done_busy got %b want %b", dwnld_busy, downloading); end
        tests++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL single_word got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                $display("[TB] single write addr=%h data=%h mask=%b", o.addr, o.data, o.mask);
                if (o !== e) begin fails++; $display("FAIL single_word got %h want %h", o, e); end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_merge();
        wr_t e, o;
        bit  ok;
        int  done;
        exp_q.push_back(byte_word(25'h000040, 8'h77));
        send_byte(25'h000040, 8'h77);
        wait_we(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL merge_start got timeout want prog_we"); end
        // Complement of the head itself must not merge: the head is on the bus.
        exp_q.push_back(byte_word(25'h000041, 8'h55));
        send_byte(25'h000041, 8'h55);
`ifdef JTFRAME_PROG_BSWAP_EN
        exp_q.push_back({22'h8, 16'h1020, 2'b00});
`else
        exp_q.push_back({22'h8, 16'h2010, 2'b00});
`endif
        send_byte(25'h000010, 8'h10);
        send_byte(25'h000011, 8'h20);
        downloading = 1'b0;
        #1;
        tests++;
        if (dwnld_busy !== 1'b1) begin fails++; $display("FAIL drain_busy got %b want 1", dwnld_busy); end
        release_writes(4, done);
        tests += 3;
        if (done != 3) begin fails++; $display("FAIL merge_writes got %0d want 3", done); end
        if (dwnld_busy !== 1'b0) begin fails++; $display("FAIL drain_idle got %b want 0", dwnld_busy); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL merge_ovf got %b want 0", overflow); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL merge_word got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                $display("[TB] merge write addr=%h data=%h mask=%b", o.addr, o.data, o.mask);
                if (o !== e) begin fails++; $display("FAIL merge_word got %h want %h", o, e); end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_overflow();
        wr_t e, o;
        int  done;
        downloading = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(byte_word(25'h001000 + 25'(i * 4), 8'hC0 + 8'(i)));
            send_byte(25'h001000 + 25'(i * 4), 8'hC0 + 8'(i));
        end
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b want 1", overflow); end
        release_writes(6, done);
        tests += 2;
        if (done != 5) begin fails++; $display("FAIL ovf_writes got %0d want 5", done); end
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        downloading = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_fall got %b want 1", overflow); end
        downloading = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b want 0", overflow); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL ovf_word got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                $display("[TB] ovf write addr=%h data=%h mask=%b", o.addr, o.data, o.mask);
                if (o !== e) begin fails++; $display("FAIL ovf_word got %h want %h", o, e); end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_full_pop();
        wr_t e, o;
        int  done;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(byte_word(25'h002000 + 25'(i * 4), 8'h30 + 8'(i)));
            send_byte(25'h002000 + 25'(i * 4), 8'h30 + 8'(i));
        end
        tests++;
        if (u_if.prog_we !== 1'b1) begin fails++; $display("FAIL full_we got %b want 1", u_if.prog_we); end
        exp_q.push_back(byte_word(25'h002100, 8'h5A));
        @(posedge clk); #1;
        ioctl_addr = 25'h002100;
        ioctl_dout = 8'h5A;
        ioctl_wr   = 1'b1;
        u_if.prog_rdy = 1'b1;
        @(posedge clk); #1;
        ioctl_wr   = 1'b0;
        u_if.prog_rdy = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
        release_writes(6, done);
        tests++;
        if (done != 5) begin fails++; $display("FAIL fullpop_writes got %0d want 5", done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL fullpop_word got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                $display("[TB] fullpop write addr=%h data=%h mask=%b", o.addr, o.data, o.mask);
                if (o !== e) begin fails++; $display("FAIL fullpop_word got %h want %h", o, e); end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_lanes();
        wr_t e, o;
        int  done;
        exp_q.push_back(byte_word(25'h000000, 8'h3C));
        exp_q.push_back(byte_word(25'h000203, 8'h4D));
        send_byte(25'h000000, 8'h3C);
        @(posedge clk); #1;
        tests += 2;
        if (u_if.prog_addr !== '0) begin fails++; $display("FAIL lane_addr got %h want 0", u_if.prog_addr); end
        if (u_if.prog_mask !== lane_mask(1'b0)) begin fails++; $display("FAIL lane_mask got %b want %b", u_if.prog_mask, lane_mask(1'b0)); end
        send_byte(25'h000203, 8'h4D);
        release_writes(3, done);
        tests++;
        if (done != 2) begin fails++; $display("FAIL lane_writes got %0d want 2", done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL lane_word got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                $display("[TB] lane write addr=%h data=%h mask=%b", o.addr, o.data, o.mask);
                if (o !== e) begin fails++; $display("FAIL lane_word got %h want %h", o, e); end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_ignored();
        downloading = 1'b0;
        @(posedge clk); #1;
        send_byte(25'h000030, 8'h99);
        repeat (4) @(posedge clk);
        #1;
        tests += 3;
        if (u_if.prog_we !== 1'b0) begin fails++; $display("FAIL ignore_we got %b want 0", u_if.prog_we); end
        if (dwnld_busy !== 1'b0) begin fails++; $display("FAIL ignore_busy got %b want 0", dwnld_busy); end
        if (obs_q.size() != 0) begin fails++; $display("FAIL ignore_writes got %0d want 0", obs_q.size()); end
        $display("[TB] ignored byte while not downloading");
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        downloading = 1'b1;
        send_byte(25'h000060, 8'h11);
        send_byte(25'h000064, 8'h22);
        wait_we(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rstw_start got timeout want prog_we"); end
        downloading = 1'b0;
        rst = 1'b1;
        #1;
        tests += 4;
        if (u_if.prog_we !== 1'b0) begin fails++; $display("FAIL rstw_we got %b want 0", u_if.prog_we); end
        if (u_if.prog_mask !== 2'b11) begin fails++; $display("FAIL rstw_mask got %b want 11", u_if.prog_mask); end
        if (u_if.prog_addr !== '0) begin fails++; $display("FAIL rstw_addr got %h want 0", u_if.prog_addr); end
        if (dwnld_busy !== 1'b0) begin fails++; $display("FAIL rstw_busy got %b want 0", dwnld_busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        tests += 2;
        if (u_if.prog_we !== 1'b0) begin fails++; $display("FAIL rstw_after_we got %b want 0", u_if.prog_we); end
        if (obs_q.size() != 0) begin fails++; $display("FAIL rstw_writes got %0d want 0", obs_q.size()); end
        $display("[TB] reset during write abandoned queue");
    endtask

    initial begin
        u_if.prog_rdy = 1'b0;
        test_reset();
        test_single();
        test_merge();
        test_overflow();
        test_full_pop();
        test_lanes();
        test_ignored();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "watchdog");
    end

endmodule
